data_mem_arbiter: RTL and testbench

//  Shares the single 128-bit block data memory between two block-level requesters: port 0 = I-cache refill, port 1 = D-cache refill/writeback.

---
 rtl/data_mem_arbiter_pkg.sv | 23 ++
 rtl/data_mem_arbiter_if.sv | 27 ++
 rtl/data_mem_arb_pick.sv | 21 ++
 rtl/data_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_data_mem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the two-requester block data memory arbiter:
// FSM state encoding, requester ids and default bus widths.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_DEF      = 28;
  localparam int DATA_W_DEF      = 128;
  localparam int TIMEOUT_CYC_DEF = 1024;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  // Exactly one of READ/WRITE makes a request; both high is illegal and ignored.
  function automatic logic req_valid(input logic rd, input logic wr);
    return rd ^ wr;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Block memory handshake bundle, shared by each requester link and by the memory link.
interface data_mem_arbiter_if #(
  parameter int ADDR_W = data_mem_arbiter_pkg::ADDR_W_DEF,
  parameter int DATA_W = data_mem_arbiter_pkg::DATA_W_DEF
);
  // Handshake: the master raises exactly one of READ/WRITE and holds it plus
  // ADDRESS/WRITEDATA stable while BUSYWAIT is high; the cycle BUSYWAIT is low
  // with the request still up is the completion (READDATA valid for reads),
  // after which the master drops or changes its request at the next edge.
  logic              READ;
  logic              WRITE;
  logic [ADDR_W-1:0] ADDRESS;
  logic [DATA_W-1:0] WRITEDATA;
  logic [DATA_W-1:0] READDATA;
  logic              BUSYWAIT;

  modport master (
    output READ, WRITE, ADDRESS, WRITEDATA,
    input  READDATA, BUSYWAIT
  );

  modport slave (
    input  READ, WRITE, ADDRESS, WRITEDATA,
    output READDATA, BUSYWAIT
  );

endinterface

// File: rtl/data_mem_arb_pick.sv
// Two-way round-robin selector: on a tie the requester not served last time wins.
module data_mem_arb_pick import data_mem_arbiter_pkg::*; (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant,
  output logic any
);

  always_comb begin
    any = valid0 | valid1;
    if (valid0 && valid1) begin
      grant = ~last_grant;
    end else if (valid1) begin
      grant = REQ_D;
    end else begin
      grant = REQ_I;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Serialises I-cache (r0) and D-cache (r1) block transactions onto one block
// memory, presenting each requester the memory's own READ/WRITE/BUSYWAIT handshake.
module data_mem_arbiter import data_mem_arbiter_pkg::*; #(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                CLK,
  input  logic                RESETN,
  data_mem_arbiter_if.slave   r0,
  data_mem_arbiter_if.slave   r1,
  data_mem_arbiter_if.master  mem,
  output logic                TIMEOUT,
  output arb_state_e          dbg_state
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic              timeout_q, timeout_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              valid0, valid1;
  logic              pick_grant, pick_any;
  logic              sel_read;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign valid0 = req_valid(r0.READ, r0.WRITE);
  assign valid1 = req_valid(r1.READ, r1.WRITE);

  data_mem_arb_pick u_pick (
    .valid0     (valid0),
    .valid1     (valid1),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .any        (pick_any)
  );

  always_comb begin
    if (pick_grant == REQ_D) begin
      sel_read  = r1.READ;
      sel_addr  = r1.ADDRESS;
      sel_wdata = r1.WRITEDATA;
    end else begin
      sel_read  = r0.READ;
      sel_addr  = r0.ADDRESS;
      sel_wdata = r0.WRITEDATA;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    wait_cnt_d   = wait_cnt_q;
    timeout_d    = 1'b0;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d      = pick_grant;
          last_grant_d = pick_grant;
          addr_d       = sel_addr;
          wdata_d      = sel_wdata;
          mem_read_d   = sel_read;
          mem_write_d  = ~sel_read;
          wait_cnt_d   = '0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // BUSYWAIT is only trusted from the second WAIT cycle, once the memory
        // has seen the strobe; a normal finish beats the timeout in the last cycle.
        if ((wait_cnt_q != '0) && !mem.BUSYWAIT) begin
          if (mem_read_q) begin
            if (grant_q == REQ_D) rdata1_d = mem.READDATA;
            else                  rdata0_d = mem.READDATA;
          end
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = ST_DONE;
        end else if (wait_cnt_q == CNT_LAST) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          timeout_d   = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q      <= ST_IDLE;
      grant_q      <= REQ_I;
      last_grant_q <= REQ_D;
      addr_q       <= '0;
      wdata_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      wait_cnt_q   <= '0;
      timeout_q    <= 1'b0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      wait_cnt_q   <= wait_cnt_d;
      timeout_q    <= timeout_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  // The completion cycle is DONE with this requester granted.
  assign r0.BUSYWAIT = valid0 & ~((state_q == ST_DONE) & (grant_q == REQ_I));
  assign r1.BUSYWAIT = valid1 & ~((state_q == ST_DONE) & (grant_q == REQ_D));
  assign r0.READDATA = rdata0_q;
  assign r1.READDATA = rdata1_q;

  assign mem.READ      = mem_read_q;
  assign mem.WRITE     = mem_write_q;
  assign mem.ADDRESS   = addr_q;
  assign mem.WRITEDATA = wdata_q;

  assign TIMEOUT   = timeout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: behavioural block memory, per-port drivers,
// and a completion scoreboard fed at issue time and drained by a monitor.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int ADDR_W = 28;
  localparam int DATA_W = 128;
  localparam int TO_CYC = 16;
  localparam int EW     = DATA_W + 2;
  localparam logic [DATA_W-1:0] PAT  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [DATA_W-1:0] WBLK = 128'hDEAD_0001_2345_6789_ABCD_EF01_2345_BEEF;

  logic       clk;
  logic       rst_n;
  logic       timeout;
  arb_state_e dbg_state;

  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r0_if ();
  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) r1_if ();
  data_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_if ();

  data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO_CYC)) dut (
    .CLK       (clk),
    .RESETN    (rst_n),
    .r0        (r0_if),
    .r1        (r1_if),
    .mem       (mem_if),
    .TIMEOUT   (timeout),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem_arr [16];
  logic [15:0]       mem_vld = '0;
  logic [DATA_W-1:0] mem_rdata;
  int                mem_lat = 4;
  bit                mem_hang = 1'b0;
  int                mem_cnt;
  logic              prev_rd, prev_wr;
  int                rd_rises = 0;
  int                wr_rises = 0;

  function automatic logic [DATA_W-1:0] mem_default(input logic [ADDR_W-1:0] a);
    if (a == 28'h0000010) return PAT;
    return {4{4'h0, a}};
  endfunction

  assign mem_if.BUSYWAIT = (mem_if.READ | mem_if.WRITE) & (mem_hang | (mem_cnt < mem_lat));
  assign mem_if.READDATA = mem_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_cnt   <= 0;
      prev_rd   <= 1'b0;
      prev_wr   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      mem_cnt <= (mem_if.READ | mem_if.WRITE) ? mem_cnt + 1 : 0;
      prev_rd <= mem_if.READ;
      prev_wr <= mem_if.WRITE;
      if (mem_if.READ && !prev_rd)  rd_rises <= rd_rises + 1;
      if (mem_if.WRITE && !prev_wr) wr_rises <= wr_rises + 1;
      if (mem_if.WRITE && !mem_if.BUSYWAIT) begin
        mem_arr[mem_if.ADDRESS[7:4]] <= mem_if.WRITEDATA;
        mem_vld[mem_if.ADDRESS[7:4]] <= 1'b1;
      end
      mem_rdata <= mem_vld[mem_if.ADDRESS[7:4]] ? mem_arr[mem_if.ADDRESS[7:4]]
                                                : mem_default(mem_if.ADDRESS);
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0]     exp_q[$];
  int                checks = 0;
  int                errors = 0;
  int                to_cycles = 0;
  logic [DATA_W-1:0] exp_rd0, exp_rd1;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic port, input logic to, input logic [DATA_W-1:0] d);
    exp_q.push_back({port, to, d});
  endtask

  // ---------------- monitor ----------------
  task automatic mon_port(input logic port, input logic v, input logic bw, input logic [DATA_W-1:0] rdata);
    logic [EW-1:0] e;
    if (v && !bw) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: port %0d completed, no transaction expected", port);
      end else begin
        e = exp_q.pop_front();
        check("done_port",     DATA_W'(port),                         DATA_W'(e[EW-1]));
        check("done_readdata", rdata,                                 e[DATA_W-1:0]);
        check("done_timeout",  DATA_W'(timeout),                      DATA_W'(e[DATA_W]));
        check("done_strobe",   DATA_W'(mem_if.READ | mem_if.WRITE),   '0);
      end
    end
  endtask

  task automatic mon_step();
    if (rst_n) begin
      mon_port(1'b0, r0_if.READ ^ r0_if.WRITE, r0_if.BUSYWAIT, r0_if.READDATA);
      mon_port(1'b1, r1_if.READ ^ r1_if.WRITE, r1_if.BUSYWAIT, r1_if.READDATA);
      if (timeout) to_cycles++;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input int port, input logic rd, input logic wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (port == 0) begin
      r0_if.READ = rd; r0_if.WRITE = wr; r0_if.ADDRESS = a; r0_if.WRITEDATA = d;
    end else begin
      r1_if.READ = rd; r1_if.WRITE = wr; r1_if.ADDRESS = a; r1_if.WRITEDATA = d;
    end
  endtask

  // Called just after a rising edge; returns cycles until BUSYWAIT was seen low.
  task automatic req(input int port, input logic rd, input logic [ADDR_W-1:0] a,
                     input logic [DATA_W-1:0] d, output int lat);
    bit done;
    done = 1'b0;
    lat  = 0;
    drive(port, rd, ~rd, a, d);
    while (!done && lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      done = (port == 0) ? !r0_if.BUSYWAIT : !r1_if.BUSYWAIT;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL req_timeout: port %0d got no completion within %0d cycles, required one", port, lat);
    end
    @(posedge clk);
    #1;
    drive(port, 1'b0, 1'b0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, lat0, lat1, rd0, wr0, bad;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    exp_rd0 = '0;
    exp_rd1 = '0;
    fork
      forever @(negedge clk) mon_step();
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_read",   DATA_W'(mem_if.READ),      '0);
    check("rst_mem_write",  DATA_W'(mem_if.WRITE),     '0);
    check("rst_mem_addr",   DATA_W'(mem_if.ADDRESS),   '0);
    check("rst_mem_wdata",  mem_if.WRITEDATA,          '0);
    check("rst_r0_rdata",   r0_if.READDATA,            '0);
    check("rst_r1_rdata",   r1_if.READDATA,            '0);
    check("rst_timeout",    DATA_W'(timeout),          '0);
    check("rst_state",      DATA_W'(dbg_state),        DATA_W'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: single read, memory busy 4 cycles
    push_exp(1'b0, 1'b0, PAT);
    req(0, 1'b1, 28'h0000010, '0, lat);
    exp_rd0 = PAT;
    check("t1_latency", DATA_W'(lat), DATA_W'(6));
    check("t1_rd_rises", DATA_W'(rd_rises), DATA_W'(1));

    // 2: write then read back on requester 1
    push_exp(1'b1, 1'b0, exp_rd1);
    req(1, 1'b0, 28'h0000020, WBLK, lat);
    check("t2_wr_latency", DATA_W'(lat), DATA_W'(6));
    check("t2_wr_rises", DATA_W'(wr_rises), DATA_W'(1));
    push_exp(1'b1, 1'b0, WBLK);
    req(1, 1'b1, 28'h0000020, '0, lat);
    exp_rd1 = WBLK;
    check("t2_rd_rises", DATA_W'(rd_rises), DATA_W'(2));
    check("t2_wr_rises_after", DATA_W'(wr_rises), DATA_W'(1));

    // 3: simultaneous continuous requests alternate 0,1,0,1
    push_exp(1'b0, 1'b0, mem_default(28'h0000050));
    push_exp(1'b1, 1'b0, mem_default(28'h0000060));
    push_exp(1'b0, 1'b0, mem_default(28'h0000070));
    push_exp(1'b1, 1'b0, mem_default(28'h0000080));
    fork
      begin
        req(0, 1'b1, 28'h0000050, '0, lat0);
        req(0, 1'b1, 28'h0000070, '0, lat0);
      end
      begin
        req(1, 1'b1, 28'h0000060, '0, lat1);
        req(1, 1'b1, 28'h0000080, '0, lat1);
      end
    join
    exp_rd0 = mem_default(28'h0000070);
    exp_rd1 = mem_default(28'h0000080);
    check("t3_rd_rises", DATA_W'(rd_rises), DATA_W'(6));

    // 4: illegal request on r0 is ignored while r1 is served
    rd0 = rd_rises;
    wr0 = wr_rises;
    push_exp(1'b1, 1'b0, mem_default(28'h0000090));
    fork
      begin
        bad = 0;
        drive(0, 1'b1, 1'b1, 28'h0000010, WBLK);
        repeat (10) begin
          @(negedge clk);
          if (r0_if.BUSYWAIT) bad++;
        end
        check("t4_illegal_busywait_cycles", DATA_W'(bad), '0);
        check("t4_r0_rdata_kept", r0_if.READDATA, exp_rd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, '0, '0);
      end
      req(1, 1'b1, 28'h0000090, '0, lat1);
    join
    exp_rd1 = mem_default(28'h0000090);
    check("t4_rd_rises", DATA_W'(rd_rises - rd0), DATA_W'(1));
    check("t4_wr_rises", DATA_W'(wr_rises - wr0), '0);

    // 5: memory never finishes -> timeout, READDATA unchanged
    mem_hang = 1'b1;
    push_exp(1'b0, 1'b1, exp_rd0);
    req(0, 1'b1, 28'h00000A0, '0, lat);
    mem_hang = 1'b0;
    check("t5_latency", DATA_W'(lat), DATA_W'(TO_CYC + 1));
    check("t5_timeout_cycles", DATA_W'(to_cycles), DATA_W'(1));

    // 6: reset during WAIT drops the strobe at once, then a fresh request works
    drive(1, 1'b1, 1'b0, 28'h00000B0, '0);
    repeat (3) @(posedge clk);
    #2;
    check("t6_pre_strobe", DATA_W'(mem_if.READ), DATA_W'(1));
    rst_n = 1'b0;
    #1;
    check("t6_mem_read",  DATA_W'(mem_if.READ),  '0);
    check("t6_mem_write", DATA_W'(mem_if.WRITE), '0);
    check("t6_r0_rdata",  r0_if.READDATA,        '0);
    check("t6_r1_rdata",  r1_if.READDATA,        '0);
    check("t6_timeout",   DATA_W'(timeout),      '0);
    check("t6_state",     DATA_W'(dbg_state),    DATA_W'(ST_IDLE));
    drive(1, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_rd0 = '0;
    exp_rd1 = '0;
    @(posedge clk);
    #1;
    push_exp(1'b1, 1'b0, mem_default(28'h00000C0));
    req(1, 1'b1, 28'h00000C0, '0, lat);
    check("t6_latency", DATA_W'(lat), DATA_W'(6));
    check("t6_r0_rdata_after", r0_if.READDATA, exp_rd0);
    check("t6_timeout_cycles", DATA_W'(to_cycles), DATA_W'(1));

    repeat (2) @(posedge clk);
    check("queue_empty", DATA_W'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
